ams_pwm_dac: RTL and testbench
==============================

Name: ams_pwm_dac

Overview:
Consumer end of the analog-mixed-signal PWM DAC register interface. It takes the 24-bit per-channel DAC words written by software through the AMS register block and turns each into a 1-bit PWM stream, which feeds an external RC-filtered analog output. Each word holds an 8-bit base duty and a 16-bit dither pattern spread over a 16-cycle frame, giving an effective resolution of 12 bits. All channels share one counter chain and update on frame boundaries only, so outputs never glitch.

Parameters:
CHN, 4, number of PWM channels.
CYC, 256, clocks per PWM cycle; fixed by the 8-bit base field and not legal to override.

Ports:
clk_i  in  1  clock.
rstn_i  in  1  reset; synchronous, active-low.
cfg_i  in  CHN*24  packed DAC words; channel n in bits [24n+23:24n]. Bits [23:16] are the base duty B; bits [15:0] are the dither pattern P.
pwm_o  out  CHN  PWM outputs, registered.
frame_o  out  1  one-clock pulse marking the first clock of each 4096-clock frame.
cycle_o  out  1  one-clock pulse marking the first clock of each 256-clock cycle; coincides with frame_o at frame start.

Behaviour:
- Timing hierarchy:
  - Clock counter cnt runs 0..255; cycle counter k runs 0..15.
  - One frame = 16 cycles = 4096 clocks. Both counters wrap to 0 after 255/15.
- Reset (rstn_i=0 at a rising edge):
  - cnt=0, k=0, all shadow words = 0.
  - pwm_o=0, frame_o=0, cycle_o=0.
  - Reset wins over every other event, including mid-frame.
- Frame start:
  - The first rising edge with rstn_i=1 after reset is a frame-start edge.
  - Every 4096th edge after that is also a frame-start edge.
  - At a frame-start edge:
    - cfg_i is sampled into per-channel shadow registers.
    - frame_o and cycle_o are set to 1 for the following clock.
    - The first clock of the new frame is driven on pwm_o using the just-sampled value.
- Config updates:
  - Changes on cfg_i between frame-start edges have no effect.
  - There is no handshake. Software writes at any time; the write takes effect at the next frame start, at most 4096 clocks later.
- Threshold:
  - For cycle k, thr = B + P[k], computed as 9-bit unsigned, range 0..256.
  - P bit 0 applies to the first cycle of the frame; bit 15 applies to the last.
- Output:
  - In clock j of cycle k (j = 0..255 as seen on pwm_o), pwm_o[n] = 1 iff j < thr_n.
  - The pulse is left-aligned, high first in each cycle.
  - thr = 0 gives low for the whole cycle.
  - thr = 256 (B=255, P[k]=1) gives high for the whole cycle with no 1-clock gap at cycle or frame boundaries.
- Duty:
  - High clocks per frame = 16*B + popcount(P), out of 4096.
  - Monotonic in the word value treated as {B, popcount(P)}.
- Pulses:
  - cycle_o pulses every 256 clocks.
  - frame_o pulses every 4096 clocks.
  - Neither ever goes high for 2 consecutive clocks.
- Channel independence:
  - All channels are phase-aligned, sharing cnt and k.
  - There is no cross-channel interaction.
- Latency: from a cfg_i change to its effect on pwm_o, between 1 and 4096 clocks, determined solely by frame position.

Test Plan:
1. Zero word: cfg_i=0 on all channels, run 3 frames -> pwm_o constant 0; frame_o pulses exactly 4096 clocks apart; cycle_o pulses exactly 256 clocks apart.
2. Base only: channel 0 = 24'h0F_0000 -> every cycle has 15 high clocks then 241 low; 240 high clocks per frame.
3. Dither: channel 1 = 24'h4E_0001 -> cycle 0 high 79 clocks, cycles 1-15 high 78; 1249 per frame. Channel 2 = 24'h75_8000 -> only cycle 15 high 118, others 117.
4. Full scale: 24'hFF_FFFF -> pwm_o stays 1 continuously across at least 2 frame boundaries. 24'hFF_0000 -> exactly 1 low clock at the end of each cycle.
5. Mid-frame update: change channel 3 from 24'h9C_0000 to 24'h10_0000 at clock 1000 of a frame -> the remaining cycles of that frame stay at 156 high clocks; 16 high clocks from the next frame_o onward.
6. Reset mid-frame: assert rstn_i for 3 clocks at clock 2100 of a frame -> pwm_o, frame_o and cycle_o are 0 from the next clock. On release, frame_o is high one clock after the first edge with rstn_i=1, and cfg_i is resampled at that edge.

Source files
------------

// File: rtl/ams_pwm_dac.sv
// ams_pwm_dac: multi-channel dithered PWM DAC.
//
// Each channel takes a 24-bit word {B[7:0], P[15:0]} and produces a left-aligned PWM
// stream. Within each 256-clock cycle k (k = 0..15), the output is high for thr = B + P[k]
// clocks. Sixteen cycles form one 4096-clock frame, so the effective resolution is 12 bits.
// Words are shadowed only at frame start, so an update can never produce a partial frame.
//
// Ports:
//   clk_i    clock
//   rstn_i   synchronous active-low reset
//   cfg_i    packed DAC words; channel n occupies bits [24n+23:24n]
//   pwm_o    registered PWM outputs, one per channel
//   frame_o  one-clock pulse on the first clock of each frame
//   cycle_o  one-clock pulse on the first clock of each 256-clock cycle
module ams_pwm_dac #(
  parameter int unsigned CHN = 4
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic [CHN*24-1:0] cfg_i,
  output logic [CHN-1:0]    pwm_o,
  output logic              frame_o,
  output logic              cycle_o
);

  // The 8-bit base field fixes the cycle length, so CYC cannot be overridden.
  localparam int unsigned CYC    = 256;
  localparam int unsigned NumCyc = 16;
  localparam int unsigned CntW   = $clog2(CYC);
  localparam int unsigned KW     = $clog2(NumCyc);

  localparam logic [CntW-1:0] CntMax = CntW'(CYC - 1);
  localparam logic [KW-1:0]   KMax   = KW'(NumCyc - 1);

  // cnt_q/k_q give the position of the clock that will be driven on pwm_o after the next
  // edge. Reset clears them to 0, so the first edge out of reset is a frame start.
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [KW-1:0]   k_q, k_d;
  logic [23:0]     shadow_q [CHN];
  logic [23:0]     shadow_d [CHN];
  logic [15:0]     pat      [CHN];
  logic [8:0]      thr      [CHN];
  logic [CHN-1:0]  pwm_d;
  logic            frame_start;
  logic            cycle_start;

  always_comb begin
    frame_start = (cnt_q == '0) && (k_q == '0);
    cycle_start = (cnt_q == '0);

    cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + CntW'(1);
    k_d   = k_q;
    if (cnt_q == CntMax) begin
      k_d = (k_q == KMax) ? '0 : k_q + KW'(1);
    end

    for (int n = 0; n < CHN; n++) begin
      // At frame start the just-sampled word drives the very first clock of the frame.
      shadow_d[n] = frame_start ? cfg_i[24*n +: 24] : shadow_q[n];
      pat[n]      = shadow_d[n][15:0];
      // 9-bit threshold so B=255 with a dither bit gives 256, i.e. high for the whole cycle.
      thr[n]      = {1'b0, shadow_d[n][23:16]} + 9'(pat[n][k_q]);
      pwm_d[n]    = ({1'b0, cnt_q} < thr[n]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      cnt_q   <= '0;
      k_q     <= '0;
      pwm_o   <= '0;
      frame_o <= 1'b0;
      cycle_o <= 1'b0;
      for (int n = 0; n < CHN; n++) begin
        shadow_q[n] <= '0;
      end
    end else begin
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      pwm_o   <= pwm_d;
      frame_o <= frame_start;
      cycle_o <= cycle_start;
      for (int n = 0; n < CHN; n++) begin
        shadow_q[n] <= shadow_d[n];
      end
    end
  end

endmodule

// File: tb/tb_ams_pwm_dac.sv
// Bench for ams_pwm_dac: directed words plus random words and update times, checked every
// clock against a frame-position model and once per frame against the duty formula.
module tb_ams_pwm_dac;

  localparam int unsigned CHN   = 4;
  localparam int unsigned FRAME = 4096;

  logic              clk;
  logic              rstn;
  logic [CHN*24-1:0] cfg;
  logic [CHN-1:0]    pwm;
  logic              frame;
  logic              cycle;

  ams_pwm_dac #(
    .CHN(CHN)
  ) u_dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .cfg_i  (cfg),
    .pwm_o  (pwm),
    .frame_o(frame),
    .cycle_o(cycle)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: pos is the frame position (0..4095) of the clock shown after the next
  // edge; the word in force is whatever cfg held at the last frame-start edge.
  int unsigned  pos = 0;
  logic [23:0]  mshadow  [CHN];
  int unsigned  duty_exp [CHN];
  int unsigned  hi_cnt   [CHN];
  bit           frame_valid = 0;
  logic [CHN-1:0] exp_pwm;
  logic         exp_frame, exp_cycle;
  int unsigned  j, k, t_thr;
  longint unsigned cyc_no = 0;
  longint unsigned last_frame_cyc, last_cycle_cyc;
  bit           frame_seen = 0, cycle_seen = 0;
  logic         prev_frame = 1'b0, prev_cycle = 1'b0;

  always @(posedge clk) begin
    cyc_no++;
    if (!rstn) begin
      exp_pwm     = '0;
      exp_frame   = 1'b0;
      exp_cycle   = 1'b0;
      pos         = 0;
      frame_valid = 0;
      frame_seen  = 0;
      cycle_seen  = 0;
      for (int n = 0; n < CHN; n++) mshadow[n] = '0;
    end else begin
      if (pos == 0) begin
        for (int n = 0; n < CHN; n++) begin
          if (frame_valid) check_eq($sformatf("duty%0d", n), hi_cnt[n], duty_exp[n]);
          mshadow[n]  = cfg[24*n +: 24];
          duty_exp[n] = 16 * int'(mshadow[n][23:16]) + $countones(mshadow[n][15:0]);
          hi_cnt[n]   = 0;
        end
        frame_valid = 1;
      end
      j = pos % 256;
      k = pos / 256;
      for (int n = 0; n < CHN; n++) begin
        t_thr      = int'(mshadow[n][23:16]) + int'(mshadow[n][k]);
        exp_pwm[n] = (j < t_thr);
      end
      exp_frame = (pos == 0);
      exp_cycle = (j == 0);
      pos = (pos + 1) % FRAME;
    end

    #1;
    for (int n = 0; n < CHN; n++) begin
      check_eq($sformatf("pwm%0d", n), 32'(pwm[n]), 32'(exp_pwm[n]));
      if (pwm[n]) hi_cnt[n]++;
    end
    check_eq("frame_o", 32'(frame), 32'(exp_frame));
    check_eq("cycle_o", 32'(cycle), 32'(exp_cycle));
    check_eq("frame_run", 32'(frame && prev_frame), 32'd0);
    check_eq("cycle_run", 32'(cycle && prev_cycle), 32'd0);
    if (rstn && frame) begin
      if (frame_seen) check_eq("frame_gap", 32'(cyc_no - last_frame_cyc), FRAME);
      last_frame_cyc = cyc_no;
      frame_seen     = 1;
    end
    if (rstn && cycle) begin
      if (cycle_seen) check_eq("cycle_gap", 32'(cyc_no - last_cycle_cyc), 32'd256);
      last_cycle_cyc = cyc_no;
      cycle_seen     = 1;
    end
    prev_frame = frame;
    prev_cycle = cycle;
  end

  // Wait for the negedge just before the edge that shows frame position p.
  task automatic wait_pos(input int unsigned p);
    int unsigned guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (pos != p && guard < 2 * FRAME);
    if (pos != p) check_eq("wait_pos", pos, p);
  endtask

  task automatic run_clks(input int unsigned c);
    repeat (c) @(negedge clk);
  endtask

  task automatic set_ch(input int unsigned n, input logic [23:0] w);
    cfg[24*n +: 24] = w;
  endtask

  initial begin
    rstn = 1'b0;
    cfg  = '0;
    run_clks(3);
    rstn = 1'b1;

    // Zero word for 3 frames.
    run_clks(3 * FRAME);

    // Base only and dither words; written one clock before a frame start.
    wait_pos(0);
    set_ch(0, 24'h0F_0000);
    set_ch(1, 24'h4E_0001);
    set_ch(2, 24'h75_8000);
    set_ch(3, 24'h00_0000);
    run_clks(2 * FRAME);

    // Full scale and near-full-scale, held across several frame boundaries.
    wait_pos(0);
    set_ch(0, 24'hFF_FFFF);
    set_ch(1, 24'hFF_0000);
    set_ch(2, 24'h00_FFFF);
    set_ch(3, 24'h01_0000);
    run_clks(3 * FRAME);

    // Mid-frame update on channel 3 takes effect only at the next frame.
    wait_pos(0);
    set_ch(3, 24'h9C_0000);
    run_clks(2);
    wait_pos(1000);
    set_ch(3, 24'h10_0000);
    run_clks(FRAME + 100);

    // Reset mid-frame, with cfg changed while reset is held.
    wait_pos(2100);
    rstn = 1'b0;
    run_clks(1);
    set_ch(0, 24'hA5_5A5A);
    set_ch(2, 24'hFF_8001);
    run_clks(2);
    rstn = 1'b1;
    run_clks(2 * FRAME);

    // Random words written at random frame positions.
    for (int it = 0; it < 3; it++) begin
      wait_pos($urandom_range(0, FRAME - 1));
      for (int n = 0; n < CHN; n++) begin
        logic [23:0] w;
        w = 24'($urandom);
        if ($urandom_range(0, 3) == 0) w[23:16] = 8'hFF;
        set_ch(n, w);
      end
      run_clks($urandom_range(FRAME / 2, FRAME));
    end
    wait_pos(0);
    run_clks(FRAME + 3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
